// File: rtl/key_event_encoder.sv
// key_event_encoder
//   Scans debounced key levels plus program / pitchshift controls and queues
//   note-on, note-off and program-change bytes in a small event FIFO, then
//   hands them one at a time to a serial/MIDI transmitter.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     ena             encoder enable
//     key             NUM_KEYS debounced key levels
//     program_num     7-bit program number
//     pitchshift      5-bit transpose amount
//     mready          transmitter idle/ready
//     data            message byte, valid while mstart=1
//     mstart          one-cycle start strobe to the transmitter
//     busy            FIFO non-empty or scanner not in SCAN
//     fifo_level      FIFO occupancy
//
//   Build option KEY_ENC_ALL_OFF_EN: when defined, dropping ena sends a
//   note-off for every held key and then holds; when undefined, dropping ena
//   clears the key state and the FIFO and silences the output.

module key_event_encoder #(
    parameter int unsigned           NUM_KEYS    = 10,
    parameter logic [6*NUM_KEYS-1:0] KEY_OFFSETS = {6'd15, 6'd14, 6'd12, 6'd10, 6'd8,
                                                    6'd7,  6'd5,  6'd3,  6'd2,  6'd0},
    parameter int unsigned           FIFO_DEPTH  = 4,
    parameter logic [4:0]            SHIFT_INIT  = 5'd7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic [NUM_KEYS-1:0]           key,
    input  logic [6:0]                    program_num,
    input  logic [4:0]                    pitchshift,
    input  logic                          mready,
    output logic [7:0]                    data,
    output logic                          mstart,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {SCAN, FLUSH, ALLOFF, HOLD} scan_e;
    typedef enum logic       {IDLE, WAIT}                out_e;

    logic [NUM_KEYS-1:0] key_q, key_reg_q, key_reg_d, diff;
    logic [4:0]          shift_q, shift_d;
    logic [6:0]          prog_q, prog_d;
    scan_e               scan_q, scan_d;
    out_e                out_q, out_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [7:0]          mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          data_q, data_d;
    logic                mstart_q, mstart_d, busy_q, busy_d;

    logic                push, pop, can_push;
    logic [7:0]          push_byte;
    logic                disabled, alloff_req;

    logic                diff_hit, diff_lvl, reg_hit;
    logic [NUM_KEYS-1:0] diff_mask, reg_mask;
    logic [5:0]          diff_off, reg_off;

    function automatic logic [7:0] note_byte(input logic [5:0] off, input logic [4:0] shift,
                                             input logic on);
        logic [5:0] note;
        note = off + {1'b0, shift};
        return {note, on, 1'b0};
    endfunction

    // Enable handling differs per build: all-off sweep vs. hard flush.
`ifdef KEY_ENC_ALL_OFF_EN
    assign disabled   = 1'b0;
    assign alloff_req = !ena && (scan_q == SCAN || scan_q == FLUSH);
`else
    assign disabled   = !ena;
    assign alloff_req = 1'b0;
`endif

    assign diff = key_q ^ key_reg_q;

    // Lowest-index changed key and lowest-index held key.
    always_comb begin
        diff_hit  = 1'b0;
        diff_mask = '0;
        diff_off  = '0;
        reg_hit   = 1'b0;
        reg_mask  = '0;
        reg_off   = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (diff[i]) begin
                diff_hit  = 1'b1;
                diff_mask = NUM_KEYS'(1) << i;
                diff_off  = 6'(KEY_OFFSETS >> (6 * i));
            end
            if (key_reg_q[i]) begin
                reg_hit  = 1'b1;
                reg_mask = NUM_KEYS'(1) << i;
                reg_off  = 6'(KEY_OFFSETS >> (6 * i));
            end
        end
        diff_lvl = |(key_q & diff_mask);
    end

    // A slot frees up when the output stage pops in the same cycle.
    assign can_push = (cnt_q != CNT_W'(FIFO_DEPTH)) || pop;

    // Scanner: one event per cycle; blocked events simply retry next cycle.
    always_comb begin
        scan_d    = scan_q;
        key_reg_d = key_reg_q;
        shift_d   = shift_q;
        prog_d    = prog_q;
        push      = 1'b0;
        push_byte = '0;
        if (disabled) begin
            key_reg_d = '0;
            scan_d    = SCAN;
        end else if (alloff_req) begin
            scan_d = ALLOFF;
        end else begin
            case (scan_q)
                SCAN: begin
                    if (shift_q != pitchshift) begin
                        scan_d = FLUSH;
                    end else if (diff_hit) begin
                        if (can_push) begin
                            push      = 1'b1;
                            push_byte = note_byte(diff_off, shift_q, diff_lvl);
                            key_reg_d = (key_reg_q & ~diff_mask) | (key_q & diff_mask);
                        end
                    end else if (prog_q != program_num) begin
                        if (can_push) begin
                            push      = 1'b1;
                            push_byte = {program_num, 1'b1};
                            prog_d    = program_num;
                        end
                    end
                end
                FLUSH, ALLOFF: begin
                    if (reg_hit) begin
                        if (can_push) begin
                            push      = 1'b1;
                            push_byte = note_byte(reg_off, shift_q, 1'b0);
                            key_reg_d = key_reg_q & ~reg_mask;
                        end
                    end else if (scan_q == FLUSH) begin
                        // Latest pitchshift is sampled only on exit.
                        shift_d = pitchshift;
                        scan_d  = SCAN;
                    end else begin
                        scan_d = HOLD;
                    end
                end
                HOLD: begin
                    if (ena) scan_d = SCAN;
                end
                default: scan_d = SCAN;
            endcase
        end
    end

    // Output handshake: pop on IDLE+mready, then wait for mready to drop.
    always_comb begin
        out_d    = out_q;
        data_d   = data_q;
        mstart_d = 1'b0;
        pop      = 1'b0;
        if (disabled) begin
            out_d  = IDLE;
            data_d = '0;
        end else begin
            case (out_q)
                IDLE: begin
                    if (mready && cnt_q != '0) begin
                        pop      = 1'b1;
                        data_d   = mem_q[rd_q];
                        mstart_d = 1'b1;
                        out_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (!mready) out_d = IDLE;
                end
                default: out_d = IDLE;
            endcase
        end
    end

    // Event FIFO pointers and storage.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (disabled) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_byte;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (pop) rd_d = rd_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
        busy_d = (cnt_d != '0) || (scan_d != SCAN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q     <= '0;
            key_reg_q <= '0;
            shift_q   <= SHIFT_INIT;
            prog_q    <= '0;
            scan_q    <= SCAN;
            out_q     <= IDLE;
            mem_q     <= '{default: '0};
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            mstart_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            key_q     <= key;
            key_reg_q <= key_reg_d;
            shift_q   <= shift_d;
            prog_q    <= prog_d;
            scan_q    <= scan_d;
            out_q     <= out_d;
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            mstart_q  <= mstart_d;
            busy_q    <= busy_d;
        end
    end

    assign data       = data_q;
    assign mstart     = mstart_q;
    assign busy       = busy_q;
    assign fifo_level = cnt_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Testbench for key_event_encoder: directed vector table, hand-written
// multi-cycle sequences and randomized key/program/pitchshift steps checked
// against an event-level reference model.

module tb_key_event_encoder;

    localparam int unsigned NK = 10;

    logic          clk = 1'b0;
    logic          rst, ena, mready;
    logic [NK-1:0] key;
    logic [6:0]    prog;
    logic [4:0]    pshift;
    logic [7:0]    data;
    logic          mstart, busy;
    logic [2:0]    fifo_level;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] rx_q [$];
    bit   tx_hold = 1'b0;
    int   offs [NK] = '{0, 2, 3, 5, 7, 8, 10, 12, 14, 15};

    typedef struct {
        logic [NK-1:0] keys;
        logic [6:0]    prog;
        logic [4:0]    shift;
        int            n;
        logic [47:0]   exp;
    } vec_t;
    vec_t vecs [7];

    key_event_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .key        (key),
        .program_num(prog),
        .pitchshift (pshift),
        .mready     (mready),
        .data       (data),
        .mstart     (mstart),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    // Transmitter model: captures each strobed byte, stays busy 1..3 cycles.
    initial begin
        mready = 1'b0;
        forever begin
            @(negedge clk);
            if (mstart) begin
                rx_q.push_back(data);
                mready = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            mready = !tx_hold;
        end
    end

    function automatic logic [7:0] note_msg(input int k, input int sh, input bit on);
        int note;
        note = (offs[k] + sh) % 64;
        return 8'(note * 4 + (on ? 2 : 0));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_quiet(input string name);
        int stable = 0;
        int c = 0;
        while (stable < 8 && c < 1000) begin
            @(negedge clk);
            c++;
            if (!busy && fifo_level == 3'd0 && mready && !mstart) stable++;
            else stable = 0;
        end
        chk({name, " quiet"}, 32'(stable >= 8), 32'd1);
    endtask

    task automatic expect_rx(input string name, input logic [7:0] exp_q [$]);
        chk({name, " count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            logic [31:0] a;
            a = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD;
            chk($sformatf("%s byte%0d", name, i), a, 32'(exp_q[i]));
        end
        rx_q.delete();
    endtask

    // Expected bytes packed first-in-MSB.
    task automatic expect_packed(input string name, input int n, input logic [47:0] e);
        logic [7:0]  q [$];
        logic [47:0] t;
        for (int j = 0; j < n; j++) begin
            t = e << (8 * j);
            q.push_back(t[47:40]);
        end
        expect_rx(name, q);
    endtask

    task automatic apply(input logic [NK-1:0] k, input logic [6:0] p, input logic [4:0] s);
        key    = k;
        prog   = p;
        pshift = s;
    endtask

    initial begin
        logic [NK-1:0] mk, nk;
        logic [6:0]    mp, np;
        logic [4:0]    ms, ns;
        logic [7:0]    eq [$];
        int            c;

        vecs[0] = '{keys: 10'h000, prog: 7'd0, shift: 5'd7, n: 1, exp: {8'h30, 40'h0}};
        vecs[1] = '{keys: 10'h000, prog: 7'd5, shift: 5'd7, n: 1, exp: {8'h0B, 40'h0}};
        vecs[2] = '{keys: 10'h001, prog: 7'd5, shift: 5'd7, n: 1, exp: {8'h1E, 40'h0}};
        vecs[3] = '{keys: 10'h001, prog: 7'd5, shift: 5'd9, n: 2, exp: {8'h1C, 8'h26, 32'h0}};
        vecs[4] = '{keys: 10'h000, prog: 7'd5, shift: 5'd9, n: 1, exp: {8'h24, 40'h0}};
        vecs[5] = '{keys: 10'h006, prog: 7'd5, shift: 5'd7, n: 2, exp: {8'h26, 8'h2A, 32'h0}};
        vecs[6] = '{keys: 10'h000, prog: 7'd5, shift: 5'd7, n: 2, exp: {8'h24, 8'h28, 32'h0}};

        rst = 1'b1;
        ena = 1'b1;
        apply(10'h000, 7'd0, 5'd7);
        repeat (3) @(negedge clk);
        chk("reset data", 32'(data), 32'h0);
        chk("reset mstart", 32'(mstart), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset level", 32'(fifo_level), 32'h0);
        rst = 1'b0;
        wait_quiet("startup");
        expect_packed("startup", 0, 48'h0);

        // Key press latency: mstart exactly after the third edge.
        key = 10'h008;
        @(negedge clk);
        chk("lat k mstart", 32'(mstart), 32'h0);
        @(negedge clk);
        chk("lat k+1 mstart", 32'(mstart), 32'h0);
        chk("lat k+1 level", 32'(fifo_level), 32'h1);
        @(negedge clk);
        chk("lat k+2 mstart", 32'(mstart), 32'h1);
        chk("lat k+2 data", 32'(data), 32'h32);
        wait_quiet("lat");
        expect_packed("lat", 1, {8'h32, 40'h0});

        for (int v = 0; v < 7; v++) begin
            apply(vecs[v].keys, vecs[v].prog, vecs[v].shift);
            wait_quiet($sformatf("vec%0d", v));
            expect_packed($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp);
        end

        // FIFO fill with the transmitter stalled, then drain in order.
        tx_hold = 1'b1;
        repeat (5) @(negedge clk);
        key = 10'h03F;
        repeat (12) @(negedge clk);
        chk("full level", 32'(fifo_level), 32'h4);
        chk("full busy", 32'(busy), 32'h1);
        chk("full no tx", 32'(rx_q.size()), 32'h0);
        tx_hold = 1'b0;
        wait_quiet("full drain");
        expect_packed("full drain", 6, {8'h1E, 8'h26, 8'h2A, 8'h32, 8'h3A, 8'h3E});
        key = 10'h000;
        wait_quiet("full rel");
        expect_packed("full rel", 6, {8'h1C, 8'h24, 8'h28, 8'h30, 8'h38, 8'h3C});
        key = 10'h006;
        wait_quiet("hold12");
        expect_packed("hold12", 2, {8'h26, 8'h2A, 32'h0});

        // Enable drop with keys 1,2 held.
        ena = 1'b0;
        repeat (30) @(negedge clk);
        chk("ena0 level", 32'(fifo_level), 32'h0);
`ifdef KEY_ENC_ALL_OFF_EN
        expect_packed("ena0", 2, {8'h24, 8'h28, 32'h0});
`else
        chk("ena0 data", 32'(data), 32'h0);
        chk("ena0 busy", 32'(busy), 32'h0);
        expect_packed("ena0", 0, 48'h0);
`endif
        ena = 1'b1;
        wait_quiet("ena1");
        expect_packed("ena1", 2, {8'h26, 8'h2A, 32'h0});

        // Reset with three events queued.
        tx_hold = 1'b1;
        repeat (5) @(negedge clk);
        key = 10'h0E6;
        c = 0;
        while (fifo_level != 3'd3 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("pre-rst level", 32'(fifo_level), 32'h3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst level", 32'(fifo_level), 32'h0);
        chk("rst mstart", 32'(mstart), 32'h0);
        chk("rst data", 32'(data), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tx_hold = 1'b0;
        wait_quiet("post-rst");
        expect_packed("post-rst", 6, {8'h0B, 8'h26, 8'h2A, 8'h3E, 8'h46, 8'h4E});

        // Randomized steps against the event-level model.
        mk = 10'h0E6;
        mp = 7'd5;
        ms = 5'd7;
        for (int s = 0; s < 60; s++) begin
            nk = ($urandom_range(0, 3) == 0) ? mk : NK'($urandom);
            np = ($urandom_range(0, 3) == 0) ? 7'($urandom) : mp;
            ns = ($urandom_range(0, 3) == 0) ? 5'($urandom) : ms;
            eq.delete();
            if (ns != ms) begin
                // Old chord released at old transpose, new chord struck at new.
                for (int i = 0; i < int'(NK); i++) if (mk[i]) eq.push_back(note_msg(i, int'(ms), 1'b0));
                for (int i = 0; i < int'(NK); i++) if (nk[i]) eq.push_back(note_msg(i, int'(ns), 1'b1));
                if (np != mp) eq.push_back({np, 1'b1});
            end else begin
                // Key input is one cycle behind, so a program change lands first.
                if (np != mp) eq.push_back({np, 1'b1});
                for (int i = 0; i < int'(NK); i++)
                    if (nk[i] != mk[i]) eq.push_back(note_msg(i, int'(ms), nk[i]));
            end
            apply(nk, np, ns);
            wait_quiet($sformatf("rand%0d", s));
            expect_rx($sformatf("rand%0d", s), eq);
            mk = nk;
            mp = np;
            ms = ns;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
